multi_evt_counter: RTL and testbench

//  N-channel modulo event counter, the parametrised successor of the single-channel event counter.

---
 rtl/evt_counter_pkg.sv | 20 ++
 rtl/evt_counter_ch.sv | 68 ++++++
 rtl/multi_evt_counter.sv | 61 ++++++
 tb/tb_multi_evt_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/evt_counter_pkg.sv
// Shared types and helpers for the event counter fabric.
package evt_counter_pkg;

  typedef enum logic {
    CNT_PERIODIC = 1'b0,
    CNT_ONESHOT  = 1'b1
  } counter_mode_t;

  localparam int unsigned MAX_WIDTH = 32;

  // Terminal count for modulus m at the given width; m == 0 selects the full 2**width range.
  function automatic logic [MAX_WIDTH-1:0] terminal(input logic [MAX_WIDTH-1:0] m,
                                                    input int unsigned width);
    logic [MAX_WIDTH-1:0] ones;
    ones = '1;
    if (m == '0) return ones >> (MAX_WIDTH - width);
    return m - MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/evt_counter_ch.sv
// One modulo event counter channel: count, wrap pulse and sticky one-shot done.
module evt_counter_ch
  import evt_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic             src_in,
  input  logic             clr_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  input  logic [WIDTH-1:0] mod_in,
  input  counter_mode_t    mode_in,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap_out,
  output logic             done_out
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] term;
  logic             cnt_evt;

  assign term    = WIDTH'(terminal(MAX_WIDTH'(mod_in), WIDTH));
  assign cnt_evt = en_in & src_in & ~done_q;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (clr_in) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load_in) begin
      count_d = load_val_in;
      done_d  = 1'b0;
    end else if (cnt_evt) begin
      // >= so a shrunk modulus or oversized load wraps on the next event
      if (count_q >= term) begin
        count_d = '0;
        wrap_d  = 1'b1;
        if (mode_in == CNT_ONESHOT) done_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count_out = count_q;
  assign wrap_out  = wrap_q;
  assign done_out  = done_q;

endmodule

// File: rtl/multi_evt_counter.sv
// N-channel modulo event counter with optional wrap cascading between adjacent channels.
module multi_evt_counter
  import evt_counter_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 17,
  parameter bit          CASCADE = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_CH-1:0]       en_in,
  input  logic [NUM_CH-1:0]       evt_in,
  input  logic [NUM_CH-1:0]       clr_in,
  input  logic [NUM_CH-1:0]       load_in,
  input  logic [NUM_CH*WIDTH-1:0] load_val_in,
  input  logic [NUM_CH*WIDTH-1:0] mod_in,
  input  logic [NUM_CH-1:0]       mode_in,
  input  logic [NUM_CH-1:0]       casc_in,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       wrap_out,
  output logic [NUM_CH-1:0]       done_out
);

  logic [NUM_CH-1:0] src;
  logic [NUM_CH-1:0] wrap_w;
  logic              casc_unused;

  // casc_in[0] has no upstream channel and is deliberately ignored
  assign casc_unused = ^casc_in;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      if (i == 0) begin : g_src0
        assign src[i] = evt_in[i];
      end else begin : g_srcn
        assign src[i] = (CASCADE && casc_in[i]) ? wrap_w[i-1] : evt_in[i];
      end

      evt_counter_ch #(
        .WIDTH(WIDTH)
      ) u_ch (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .en_in       (en_in[i]),
        .src_in      (src[i]),
        .clr_in      (clr_in[i]),
        .load_in     (load_in[i]),
        .load_val_in (load_val_in[i*WIDTH +: WIDTH]),
        .mod_in      (mod_in[i*WIDTH +: WIDTH]),
        .mode_in     (counter_mode_t'(mode_in[i])),
        .count_out   (count_out[i*WIDTH +: WIDTH]),
        .wrap_out    (wrap_w[i]),
        .done_out    (done_out[i])
      );
    end
  endgenerate

  assign wrap_out = wrap_w;

endmodule

// File: tb/tb_multi_evt_counter.sv
// Directed bench for multi_evt_counter: a 4x17 instance plus a 1x4 instance for full-range wrap.
module tb_multi_evt_counter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 17;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   en, evt, clr, load, mode, casc;
  logic [N*W-1:0] lval, modv, cnt;
  logic [N-1:0]   wrap, done;

  logic           s_en, s_evt, s_clr, s_load, s_mode, s_casc;
  logic [3:0]     s_lval, s_mod, s_cnt;
  logic           s_wrap, s_done;

  int n_checks = 0;
  int n_errors = 0;
  int wraps;

  int exp1[12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
  int exp2c[5] = '{1, 2, 0, 0, 0};
  int exp2d[5] = '{0, 0, 1, 1, 1};
  int exp2w[5] = '{0, 0, 1, 0, 0};

  always #5 clk = ~clk;

  multi_evt_counter #(.NUM_CH(N), .WIDTH(W), .CASCADE(1'b1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .evt_in(evt), .clr_in(clr),
    .load_in(load), .load_val_in(lval), .mod_in(modv), .mode_in(mode),
    .casc_in(casc), .count_out(cnt), .wrap_out(wrap), .done_out(done)
  );

  multi_evt_counter #(.NUM_CH(1), .WIDTH(4), .CASCADE(1'b0)) dut_s (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(s_en), .evt_in(s_evt), .clr_in(s_clr),
    .load_in(s_load), .load_val_in(s_lval), .mod_in(s_mod), .mode_in(s_mode),
    .casc_in(s_casc), .count_out(s_cnt), .wrap_out(s_wrap), .done_out(s_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(cnt[ch*W +: W]);
  endfunction

  initial begin
    rst_n = 1'b0;
    en = '0; evt = '0; clr = '0; load = '0; mode = '0; casc = '0;
    lval = '0; modv = '0;
    s_en = 1'b0; s_evt = 1'b0; s_clr = 1'b0; s_load = 1'b0; s_mode = 1'b0; s_casc = 1'b0;
    s_lval = '0; s_mod = '0;

    #12;
    check("rst_cnt", 32'(cnt == '0), 1);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_done", 32'(done), 0);
    check("rst_s_cnt", 32'(s_cnt), 0);
    rst_n = 1'b1;

    // 1: ch0 periodic M=5
    modv[0*W +: W] = 17'd5;
    en[0] = 1'b1;
    evt[0] = 1'b1;
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t1_cnt", cnt_of(0), 32'(exp1[i]));
      check("t1_wrap", 32'(wrap[0]), (exp1[i] == 0) ? 1 : 0);
      wraps += int'(wrap[0]);
    end
    evt[0] = 1'b0;
    check("t1_nwrap", 32'(wraps), 2);

    // 2: ch1 one-shot M=3
    modv[1*W +: W] = 17'd3;
    mode[1] = 1'b1;
    en[1] = 1'b1;
    evt[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_cnt", cnt_of(1), 32'(exp2c[i]));
      check("t2_done", 32'(done[1]), 32'(exp2d[i]));
      check("t2_wrap", 32'(wrap[1]), 32'(exp2w[i]));
    end
    evt[1] = 1'b0;
    lval[1*W +: W] = 17'd2;
    load[1] = 1'b1;
    tick();
    load[1] = 1'b0;
    check("t2_load_cnt", cnt_of(1), 2);
    check("t2_load_done", 32'(done[1]), 0);

    // 3: ch2 cascaded from ch1, both M=4; evt_in[2] held high must be ignored
    mode[1] = 1'b0;
    clr[1] = 1'b1;
    clr[2] = 1'b1;
    tick();
    clr[1] = 1'b0;
    clr[2] = 1'b0;
    check("t3_clr1", cnt_of(1), 0);
    check("t3_clr2", cnt_of(2), 0);
    modv[1*W +: W] = 17'd4;
    modv[2*W +: W] = 17'd4;
    en[2] = 1'b1;
    casc[2] = 1'b1;
    evt[2] = 1'b1;
    evt[1] = 1'b1;
    for (int t = 1; t <= 32; t++) begin
      tick();
      if (t % 4 == 0) begin
        check("t3_wrap1", 32'(wrap[1]), 1);
        check("t3_lag", cnt_of(2), 32'((t / 4 - 1) % 4));
      end else if (t % 4 == 1 && t > 1) begin
        check("t3_step", cnt_of(2), 32'(((t - 1) / 4) % 4));
      end
    end
    evt[1] = 1'b0;
    evt[2] = 1'b0;
    check("t3_pre", cnt_of(2), 3);
    tick();
    check("t3_cnt2", cnt_of(2), 0);
    check("t3_wrap2", 32'(wrap[2]), 1);
    casc[2] = 1'b0;
    en[2] = 1'b0;

    // 4: modulus shrunk below count, and oversized load, on ch3
    en[3] = 1'b1;
    modv[3*W +: W] = 17'd10;
    lval[3*W +: W] = 17'd9;
    load[3] = 1'b1;
    tick();
    load[3] = 1'b0;
    check("t4_load9", cnt_of(3), 9);
    modv[3*W +: W] = 17'd4;
    evt[3] = 1'b1;
    tick();
    evt[3] = 1'b0;
    check("t4_shrink_cnt", cnt_of(3), 0);
    check("t4_shrink_wrap", 32'(wrap[3]), 1);
    lval[3*W +: W] = 17'd7;
    load[3] = 1'b1;
    tick();
    load[3] = 1'b0;
    check("t4_load7", cnt_of(3), 7);
    check("t4_load_wrap", 32'(wrap[3]), 0);
    evt[3] = 1'b1;
    tick();
    evt[3] = 1'b0;
    check("t4_over_cnt", cnt_of(3), 0);
    check("t4_over_wrap", 32'(wrap[3]), 1);

    // 5: priority, enable gating, M=1
    modv[3*W +: W] = 17'd10;
    lval[3*W +: W] = 17'd5;
    clr[3] = 1'b1;
    load[3] = 1'b1;
    evt[3] = 1'b1;
    tick();
    check("t5_clr_prio", cnt_of(3), 0);
    clr[3] = 1'b0;
    tick();
    check("t5_load_prio", cnt_of(3), 5);
    load[3] = 1'b0;
    en[3] = 1'b0;
    tick();
    check("t5_en_off", cnt_of(3), 5);
    en[3] = 1'b1;
    tick();
    check("t5_en_on", cnt_of(3), 6);
    modv[3*W +: W] = 17'd1;
    tick();
    check("t5_m1_cnt_a", cnt_of(3), 0);
    check("t5_m1_wrap_a", 32'(wrap[3]), 1);
    tick();
    check("t5_m1_cnt_b", cnt_of(3), 0);
    check("t5_m1_wrap_b", 32'(wrap[3]), 1);
    evt[3] = 1'b0;
    tick();
    check("t5_m1_wrap_c", 32'(wrap[3]), 0);

    // 6: WIDTH=4, M=0 full range, then asynchronous reset mid-count
    s_mod = 4'd0;
    s_en = 1'b1;
    s_evt = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("t6_cnt", 32'(s_cnt), 32'(k % 16));
      check("t6_wrap", 32'(s_wrap), (k == 16) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) tick();
    s_evt = 1'b0;
    check("t6_pre_rst", 32'(s_cnt), 3);
    check("t6_pre_rst_ch0", cnt_of(0), 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_s_cnt", 32'(s_cnt), 0);
    check("t6_rst_cnt", 32'(cnt == '0), 1);
    check("t6_rst_wrap", 32'(wrap), 0);
    check("t6_rst_done", 32'(done), 0);
    rst_n = 1'b1;
    #1;
    s_evt = 1'b1;
    tick();
    s_evt = 1'b0;
    check("t6_first_evt", 32'(s_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
